// File: rtl/uart_pic_rx_if.sv
// Receiver-side bundle: serial line in, accepted byte stream and picture counters out.
// The master modport is the receiver; the slave modport is whoever drives rx and consumes bytes.
interface uart_pic_rx_if;
  logic        rx;
  logic [7:0]  po_data;
  logic        po_flag;
  logic        rx_err;
  logic [14:0] pix_cnt;
  logic        pic_done;
  logic [1:0]  dbg_state;

  // po_flag is a valid-only strobe (no ready): po_data is valid in exactly the
  // cycle po_flag is high and the consumer must take it then; it stays held afterwards.
  modport master (
    input  rx,
    output po_data, po_flag, rx_err, pix_cnt, pic_done, dbg_state
  );

  modport slave (
    output rx,
    input  po_data, po_flag, rx_err, pix_cnt, pic_done, dbg_state
  );
endinterface

// File: rtl/uart_pic_rx.sv
// UART 8N1 receiver feeding the picture RAM writer: mid-bit sampling, false-start
// rejection, framing-error strobe and a per-picture byte counter with end-of-picture pulse.
module uart_pic_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int PIC_SIZE = 29584
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  uart_pic_rx_if.master bus
);
  localparam int BIT_CNT_MAX = CLK_FREQ / BAUD;
  localparam int CNT_W       = (BIT_CNT_MAX > 2) ? $clog2(BIT_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BIT_CNT_MAX / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT_MAX - 1);
  localparam logic [14:0]      PIX_LAST = 15'(PIC_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  state_t           state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic             rx_s1_d, rx_s2_d, rx_s3_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       po_data_q, po_data_d;
  logic             po_flag_q, po_flag_d;
  logic             rx_err_q, rx_err_d;
  logic [14:0]      pix_cnt_q, pix_cnt_d;
  logic             pic_done_q, pic_done_d;

  logic start_edge, mid_pt, bit_wrap, stop_mid;

  assign start_edge = rx_s3_q & ~rx_s2_q;
  assign mid_pt     = (baud_cnt_q == CNT_MID);
  assign bit_wrap   = (baud_cnt_q == CNT_LAST);
  assign stop_mid   = (state_q == S_STOP) && mid_pt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      po_data_q  <= '0;
      po_flag_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      pix_cnt_q  <= '0;
      pic_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_s3_q    <= rx_s3_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      po_data_q  <= po_data_d;
      po_flag_q  <= po_flag_d;
      rx_err_q   <= rx_err_d;
      pix_cnt_q  <= pix_cnt_d;
      pic_done_q <= pic_done_d;
    end
  end

  // Leaving STOP at its mid-bit gives half a bit of margin to catch the next start edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_START;
      S_START: begin
        if (mid_pt && rx_s2_q) state_d = S_IDLE;
        else if (bit_wrap)     state_d = S_DATA;
      end
      S_DATA:  if (bit_wrap && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (mid_pt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_s1_d    = bus.rx;
    rx_s2_d    = rx_s1_q;
    rx_s3_d    = rx_s2_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    po_data_d  = po_data_q;
    pix_cnt_d  = pix_cnt_q;
    pic_done_d = 1'b0;

    // Holding the counter at zero in IDLE is what clears it on entry to START.
    if (state_q == S_IDLE || bit_wrap) baud_cnt_d = '0;
    else                               baud_cnt_d = baud_cnt_q + CNT_W'(1);

    if (state_q == S_START) bit_idx_d = '0;
    if (state_q == S_DATA) begin
      if (mid_pt)   shreg_d[bit_idx_q] = rx_s2_q;
      if (bit_wrap) bit_idx_d = bit_idx_q + 3'd1;
    end

    po_flag_d = stop_mid & rx_s2_q;
    rx_err_d  = stop_mid & ~rx_s2_q;

    if (po_flag_d) begin
      po_data_d  = shreg_q;
      pic_done_d = (pix_cnt_q == PIX_LAST);
      pix_cnt_d  = (pix_cnt_q == PIX_LAST) ? 15'd0 : pix_cnt_q + 15'd1;
    end
  end

  assign bus.po_data   = po_data_q;
  assign bus.po_flag   = po_flag_q;
  assign bus.rx_err    = rx_err_q;
  assign bus.pix_cnt   = pix_cnt_q;
  assign bus.pic_done  = pic_done_q;
  assign bus.dbg_state = state_q;
endmodule
